sobol_lsz: RTL and testbench

Least-significant-zero (LSZ) detector for the Sobol random-number generator. It locates the lowest bit position holding `0` in the running index word `iGray`. It reports that position both as a one-hot mask and as a binary index. The Sobol RNG uses the index to select the direction vector XORed into the next sample. Outputs are registered, so there is one cycle of latency.

---
 rtl/sobolrng_pkg.sv | 11 +
 rtl/lsz_onehot2idx.sv | 26 ++
 rtl/sobol_lsz.sv | 62 ++++++
 tb/tb_sobol_lsz.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sobolrng_pkg.sv
// Shared definitions for the Sobol random-number generator blocks:
// default index width, its log2, and the word/index typedefs.
package sobolrng_pkg;

    localparam int BITWIDTH    = 8;
    localparam int LOGBITWIDTH = $clog2(BITWIDTH);

    typedef logic [BITWIDTH-1:0]    gray_t;
    typedef logic [LOGBITWIDTH-1:0] idx_t;

endpackage : sobolrng_pkg

// File: rtl/lsz_onehot2idx.sv
// One-hot to binary encoder for the LSZ detector. Combinational.
// The mask carries at most one set bit, so the index is a plain OR of the
// positions of all set bits; no priority chain is needed. An all-zero mask
// encodes to 0.
module lsz_onehot2idx
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH    = sobolrng_pkg::BITWIDTH,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0]    oneHot,
    output logic [LOGBITWIDTH-1:0] idx
);

    // OR together the binary positions of every set mask bit
    always_comb begin
        // NOTE: default assignment first so no path leaves idx unassigned (no latch).
        idx = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            if (oneHot[i]) begin
                idx = idx | LOGBITWIDTH'(i);
            end
        end
    end

endmodule : lsz_onehot2idx

// File: rtl/sobol_lsz.sv
// Least-significant-zero detector for the Sobol RNG.
// Reports the lowest 0 bit of iGray as a one-hot mask (oOneHot) and as a
// binary position (lszIdx), both registered with one cycle of latency.
// Optional feature: define LSZ_NONE_FLAG_EN to add the oNone output, which
// flags an all-ones input word (the case where the mask is zero).
module sobol_lsz
    import sobolrng_pkg::*;
#(
    parameter int BITWIDTH    = sobolrng_pkg::BITWIDTH,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITWIDTH-1:0]    iGray,
    output logic [BITWIDTH-1:0]    oOneHot,
    output logic [LOGBITWIDTH-1:0] lszIdx
`ifdef LSZ_NONE_FLAG_EN
    ,
    output logic                   oNone
`endif
);

    logic [BITWIDTH-1:0]    maskNext;
    logic [LOGBITWIDTH-1:0] idxNext;

    // Adding one ripples through the trailing ones and lands on the lowest
    // zero; masking with ~iGray keeps only that landing bit. An all-ones word
    // wraps to zero, giving an empty mask.
    assign maskNext = ~iGray & (iGray + BITWIDTH'(1));

    lsz_onehot2idx #(
        .BITWIDTH    (BITWIDTH),
        .LOGBITWIDTH (LOGBITWIDTH)
    ) uEncoder (
        .oneHot (maskNext),
        .idx    (idxNext)
    );

    // Mask and index registers load together so they never drift apart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oOneHot <= '0;
            lszIdx  <= '0;
        end else begin
            // NOTE: non-blocking assignments for all clocked state.
            oOneHot <= maskNext;
            lszIdx  <= idxNext;
        end
    end

`ifdef LSZ_NONE_FLAG_EN
    // Flag register: set when the sampled word contains no zero bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oNone <= 1'b0;
        end else begin
            oNone <= &iGray;
        end
    end
`endif

endmodule : sobol_lsz

// File: tb/tb_sobol_lsz.sv
// Self-checking bench for sobol_lsz (8-bit build). Works with or without
// LSZ_NONE_FLAG_EN; the oNone comparisons exist only when it is defined.
module tb_sobol_lsz;

    localparam int W  = 8;
    localparam int LW = 3;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  iGray;
    logic [W-1:0]  oOneHot;
    logic [LW-1:0] lszIdx;
`ifdef LSZ_NONE_FLAG_EN
    logic          oNone;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]  gray;
        logic [W-1:0]  expMask;
        logic [LW-1:0] expIdx;
        logic          expNone;
    } vec_t;

    vec_t vecs[7];

    sobol_lsz #(
        .BITWIDTH    (W),
        .LOGBITWIDTH (LW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iGray   (iGray),
        .oOneHot (oOneHot),
        .lszIdx  (lszIdx)
`ifdef LSZ_NONE_FLAG_EN
        ,
        .oNone   (oNone)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan upward for the first 0 bit.
    function automatic void refLsz(input logic [W-1:0] x, output logic [W-1:0] m,
                                   output logic [LW-1:0] idx, output logic none);
        m    = '0;
        idx  = '0;
        none = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (x[i] == 1'b0) begin
                m[i] = 1'b1;
                idx  = LW'(i);
                none = 1'b0;
                break;
            end
        end
    endfunction

    task automatic checkOutputs(input string tag, input logic [W-1:0] m,
                                input logic [LW-1:0] idx, input logic none);
        check({tag, ".mask"}, 32'(oOneHot), 32'(m));
        check({tag, ".idx"}, 32'(lszIdx), 32'(idx));
`ifdef LSZ_NONE_FLAG_EN
        check({tag, ".none"}, 32'(oNone), 32'(none));
`else
        if (none) check({tag, ".emptyMask"}, 32'(oOneHot), 32'h0);
`endif
    endtask

    // Drive x between edges, then sample 1 time unit after the next rising edge.
    task automatic applyAndCheck(input string tag, input logic [W-1:0] x);
        logic [W-1:0]  m;
        logic [LW-1:0] idx;
        logic          none;
        @(negedge clk);
        iGray = x;
        refLsz(x, m, idx, none);
        @(posedge clk);
        #1;
        checkOutputs(tag, m, idx, none);
    endtask

    initial begin
        vecs[0] = '{gray: 8'h00, expMask: 8'h01, expIdx: 3'd0, expNone: 1'b0};
        vecs[1] = '{gray: 8'h01, expMask: 8'h02, expIdx: 3'd1, expNone: 1'b0};
        vecs[2] = '{gray: 8'h07, expMask: 8'h08, expIdx: 3'd3, expNone: 1'b0};
        vecs[3] = '{gray: 8'h7F, expMask: 8'h80, expIdx: 3'd7, expNone: 1'b0};
        vecs[4] = '{gray: 8'hF6, expMask: 8'h01, expIdx: 3'd0, expNone: 1'b0};
        vecs[5] = '{gray: 8'hFF, expMask: 8'h00, expIdx: 3'd0, expNone: 1'b1};
        vecs[6] = '{gray: 8'h00, expMask: 8'h01, expIdx: 3'd0, expNone: 1'b0};

        // Reset held: outputs at zero even while clocking a non-zero input
        rst_n = 1'b0;
        iGray = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        checkOutputs("reset", 8'h00, 3'd0, 1'b0);

        // Release with iGray = 0; first edge captures it
        @(negedge clk);
        iGray = 8'h00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutputs("firstSample", 8'h01, 3'd0, 1'b0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            iGray = vecs[i].gray;
            @(posedge clk);
            #1;
            checkOutputs($sformatf("vec%0d", i), vecs[i].expMask, vecs[i].expIdx, vecs[i].expNone);
        end

        // Latency: 0x03 then 0x0F switched right after the capturing edge
        @(negedge clk);
        iGray = 8'h03;
        @(posedge clk);
        #1;
        iGray = 8'h0F;
        #1;
        checkOutputs("latency.first", 8'h04, 3'd2, 1'b0);
        @(posedge clk);
        #1;
        checkOutputs("latency.second", 8'h10, 3'd4, 1'b0);

        // Mid-stream asynchronous reset between edges
        applyAndCheck("preReset", 8'h07);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutputs("asyncReset", 8'h00, 3'd0, 1'b0);
        iGray = 8'h3F;
        @(posedge clk);
        #1;
        checkOutputs("resetHeld", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutputs("resume", 8'h40, 3'd6, 1'b0);

        // Counter sweep through the wrap-around
        begin
            logic [W-1:0] x;
            x = 8'h00;
            for (int n = 0; n < 500; n++) begin
                applyAndCheck($sformatf("sweep%0d", n), x);
                x = x + 8'd1;
            end
        end

        // Random inputs against the reference scan
        for (int n = 0; n < 150; n++) begin
            applyAndCheck($sformatf("rand%0d", n), W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sobol_lsz
